// File: rtl/rx_protocol_if.sv
// Receive-side handshake between the UART receiver and the command decoder.
// The UART receiver presents a word with rx_rdy held high; the decoder
// consumes it with a one-cycle rx_ack pulse.
interface rx_protocol_if #(
    parameter int RX_WIDTH = 8
);
    logic [RX_WIDTH-1:0] rx_data;
    logic                rx_rdy;
    logic                rx_ack;

    // Word source (UART receiver side)
    modport master (
        output rx_data,
        output rx_rdy,
        input  rx_ack
    );

    // Word sink (command decoder side)
    modport slave (
        input  rx_data,
        input  rx_rdy,
        output rx_ack
    );
endinterface

// File: rtl/rx_protocol.sv
// Host-to-device command decoder.
// Frames are one address byte followed by NUM_BYTES data bytes, LSB first.
// A complete frame produces a single-cycle register write; a frame that
// stalls longer than TIMEOUT_CYCLES between bytes is dropped and counted.
module rx_protocol #(
    parameter int RX_WIDTH       = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ERR_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rx_protocol_if.slave          rx,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_data,
    output logic                  reg_wr,
    output logic                  frame_err,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int NUM_BYTES = (DATA_WIDTH + RX_WIDTH - 1) / RX_WIDTH;
    localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TCW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW        = NUM_BYTES * RX_WIDTH;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
    localparam logic [TCW-1:0] TC_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  wr_q, wr_d;
    logic                  ferr_q, ferr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_shadow_q, addr_shadow_d;
    logic [SW-1:0]         shadow_q, shadow_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;

    logic accept;
    logic last_byte;
    logic tc_hit;

    // A word is taken whenever one is offered outside the ack cycle; the
    // block never back-pressures, so this is the whole acceptance rule.
    assign accept    = rx.rx_rdy & ~ack_q;
    assign last_byte = (bcnt_q == LAST_BYTE);
    assign tc_hit    = (state_q == ST_DATA) && !accept && (tcnt_q == TC_LAST);

    // State and datapath registers, cleared synchronously by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ack_q         <= 1'b0;
            wr_q          <= 1'b0;
            ferr_q        <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            addr_shadow_q <= '0;
            shadow_q      <= '0;
            bcnt_q        <= '0;
            tcnt_q        <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            wr_q          <= wr_d;
            ferr_q        <= ferr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            addr_shadow_q <= addr_shadow_d;
            shadow_q      <= shadow_d;
            bcnt_q        <= bcnt_d;
            tcnt_q        <= tcnt_d;
            err_q         <= err_d;
        end
    end

    // Frame sequencing: address byte opens a frame, last data byte or an
    // inter-byte timeout closes it. A word on the terminal-count edge wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (last_byte) begin
                        state_d = ST_IDLE;
                    end
                end else if (tc_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte assembly, timeout counting, write strobe and error accounting.
    always_comb begin
        ack_d         = accept;
        wr_d          = 1'b0;
        ferr_d        = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        addr_shadow_d = addr_shadow_q;
        shadow_d      = shadow_q;
        bcnt_d        = bcnt_q;
        tcnt_d        = tcnt_q;
        err_d         = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_shadow_d = rx.rx_data[ADDR_WIDTH-1:0];
                    bcnt_d        = '0;
                    tcnt_d        = '0;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (bcnt_q == BCW'(k)) begin
                            shadow_d[k*RX_WIDTH +: RX_WIDTH] = rx.rx_data;
                        end
                    end
                    tcnt_d = '0;
                    if (last_byte) begin
                        addr_d = addr_shadow_q;
                        data_d = shadow_d[DATA_WIDTH-1:0];
                        wr_d   = 1'b1;
                        bcnt_d = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end else if (tc_hit) begin
                    ferr_d = 1'b1;
                    tcnt_d = '0;
                    bcnt_d = '0;
                    if (err_q != {ERR_WIDTH{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                bcnt_d = '0;
                tcnt_d = '0;
            end
        endcase
    end

    assign rx.rx_ack = ack_q;
    assign reg_addr  = addr_q;
    assign reg_data  = data_q;
    assign reg_wr    = wr_q;
    assign frame_err = ferr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_rx_protocol.sv
// Directed self-checking bench for rx_protocol.
// Three instances share one word source and accept in lockstep:
//   a - default parameters
//   b - TIMEOUT_CYCLES=20, ERR_WIDTH=2 (timeouts and saturation)
//   c - DATA_WIDTH=8, ADDR_WIDTH=4 (single data byte frames)
module tb_rx_protocol;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rx_protocol_if #(.RX_WIDTH(8)) ifa ();
    rx_protocol_if #(.RX_WIDTH(8)) ifb ();
    rx_protocol_if #(.RX_WIDTH(8)) ifc ();

    assign ifa.rx_data = rx_data;
    assign ifa.rx_rdy  = rx_rdy;
    assign ifb.rx_data = rx_data;
    assign ifb.rx_rdy  = rx_rdy;
    assign ifc.rx_data = rx_data;
    assign ifc.rx_rdy  = rx_rdy;

    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic        a_wr, a_ferr;
    logic [7:0]  a_errc;

    logic [7:0]  b_addr;
    logic [15:0] b_data;
    logic        b_wr, b_ferr;
    logic [1:0]  b_errc;

    logic [3:0]  c_addr;
    logic [7:0]  c_data;
    logic        c_wr, c_ferr;
    logic [7:0]  c_errc;

    rx_protocol dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (ifa.slave),
        .reg_addr  (a_addr),
        .reg_data  (a_data),
        .reg_wr    (a_wr),
        .frame_err (a_ferr),
        .err_count (a_errc)
    );

    rx_protocol #(.TIMEOUT_CYCLES(20), .ERR_WIDTH(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (ifb.slave),
        .reg_addr  (b_addr),
        .reg_data  (b_data),
        .reg_wr    (b_wr),
        .frame_err (b_ferr),
        .err_count (b_errc)
    );

    rx_protocol #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut_c (
        .clk       (clk),
        .rst       (rst),
        .rx        (ifc.slave),
        .reg_addr  (c_addr),
        .reg_data  (c_data),
        .reg_wr    (c_wr),
        .frame_err (c_ferr),
        .err_count (c_errc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors, sampled mid-cycle on the falling edge
    wr_t         a_log[$];
    wr_t         b_log[$];
    wr_t         c_log[$];
    int          a_ack_cnt = 0;
    int          a_ferr_cnt = 0;
    int          b_ferr_cnt = 0;
    int          b_ferr_cyc = 0;
    int          b_hold_viol = 0;
    int          b_wr_noack = 0;
    logic [7:0]  b_addr_prev;
    logic [15:0] b_data_prev;

    always @(negedge clk) begin
        if (ifa.rx_ack === 1'b1) a_ack_cnt++;
        if (a_ferr === 1'b1) a_ferr_cnt++;
        if (a_wr === 1'b1) a_log.push_back('{cyc, a_addr, a_data});
        if (b_wr === 1'b1) b_log.push_back('{cyc, b_addr, b_data});
        if (c_wr === 1'b1) c_log.push_back('{cyc, {4'h0, c_addr}, {8'h00, c_data}});
        if (b_ferr === 1'b1) begin
            b_ferr_cnt++;
            b_ferr_cyc = cyc;
        end
        if (b_wr === 1'b1 && ifb.rx_ack !== 1'b1) b_wr_noack++;
        if (rst === 1'b0 && b_wr !== 1'b1 &&
            (b_addr !== b_addr_prev || b_data !== b_data_prev)) b_hold_viol++;
        b_addr_prev = b_addr;
        b_data_prev = b_data;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one word and wait (bounded) for it to be acknowledged
    int last_ack_cyc = 0;
    task automatic applyStimulus(input logic [7:0] w);
        logic got;
        got     = 1'b0;
        rx_data = w;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ifb.rx_ack === 1'b1) got = 1'b1;
        end
        checkOutput($sformatf("accept_%02h", w), {31'd0, got}, 32'd1);
        last_ack_cyc = cyc;
    endtask

    task automatic goIdle();
        rx_rdy = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
        applyStimulus(a);
        applyStimulus(lo);
        applyStimulus(hi);
        goIdle();
    endtask

    // Hold reset for a few edges and confirm every output is cleared
    task automatic doReset(input string tag);
        rst    = 1'b1;
        rx_rdy = 1'b0;
        waitCycles(3);
        checkOutput({tag, "_ack"},  {31'd0, ifb.rx_ack}, 32'd0);
        checkOutput({tag, "_wr"},   {31'd0, b_wr},       32'd0);
        checkOutput({tag, "_ferr"}, {31'd0, b_ferr},     32'd0);
        checkOutput({tag, "_addr"}, {24'd0, b_addr},     32'd0);
        checkOutput({tag, "_data"}, {16'd0, b_data},     32'd0);
        checkOutput({tag, "_errc"}, {30'd0, b_errc},     32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int base_wr, base_ack, base_ferr;
        logic [31:0] exp_err;
        rx_data = 8'h00;
        rx_rdy  = 1'b0;
        rst     = 1'b1;

        // Reset state, including the default instance
        doReset("rst0");
        checkOutput("rst0_a_addr", {24'd0, a_addr}, 32'd0);
        checkOutput("rst0_a_data", {16'd0, a_data}, 32'd0);
        checkOutput("rst0_a_errc", {24'd0, a_errc}, 32'd0);

        // Single frame on default parameters
        base_wr  = a_log.size();
        base_ack = a_ack_cnt;
        sendFrame(8'h05, 8'h34, 8'h12);
        waitCycles(3);
        checkOutput("f1_wr_count", a_log.size() - base_wr, 32'd1);
        checkOutput("f1_addr", {24'd0, a_log[base_wr].addr}, 32'h05);
        checkOutput("f1_data", {16'd0, a_log[base_wr].data}, 32'h1234);
        checkOutput("f1_acks", a_ack_cnt - base_ack, 32'd3);
        checkOutput("f1_ferr", a_ferr_cnt, 32'd0);
        checkOutput("f1_lat", a_log[base_wr].cyc, last_ack_cyc);

        // Back-to-back frames with rdy held throughout
        base_wr = b_log.size();
        applyStimulus(8'h01);
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        goIdle();
        waitCycles(3);
        checkOutput("b2b_count", b_log.size() - base_wr, 32'd2);
        checkOutput("b2b_addr0", {24'd0, b_log[base_wr].addr}, 32'h01);
        checkOutput("b2b_data0", {16'd0, b_log[base_wr].data}, 32'h55AA);
        checkOutput("b2b_addr1", {24'd0, b_log[base_wr+1].addr}, 32'h02);
        checkOutput("b2b_data1", {16'd0, b_log[base_wr+1].data}, 32'hFF00);
        checkOutput("b2b_gap", b_log[base_wr+1].cyc - b_log[base_wr].cyc, 32'd6);
        checkOutput("b2b_hold", b_hold_viol, 32'd0);
        checkOutput("b2b_wr_ack", b_wr_noack, 32'd0);

        // Inter-byte timeout, then a clean frame
        base_wr   = b_log.size();
        base_ferr = b_ferr_cnt;
        applyStimulus(8'h07);
        applyStimulus(8'h11);
        goIdle();
        waitCycles(25);
        checkOutput("to_ferr", b_ferr_cnt - base_ferr, 32'd1);
        checkOutput("to_when", b_ferr_cyc - last_ack_cyc, 32'd20);
        checkOutput("to_errc", {30'd0, b_errc}, 32'd1);
        checkOutput("to_nowr", b_log.size() - base_wr, 32'd0);
        sendFrame(8'h03, 8'h22, 8'h33);
        waitCycles(3);
        checkOutput("to_next_count", b_log.size() - base_wr, 32'd1);
        checkOutput("to_next_addr", {24'd0, b_log[base_wr].addr}, 32'h03);
        checkOutput("to_next_data", {16'd0, b_log[base_wr].data}, 32'h3322);

        // Word arriving on the terminal-count edge wins over the timeout
        doReset("rst1");
        base_wr   = b_log.size();
        base_ferr = b_ferr_cnt;
        applyStimulus(8'h07);
        applyStimulus(8'h11);
        goIdle();
        repeat (19) @(posedge clk);
        #1;
        applyStimulus(8'h22);
        goIdle();
        waitCycles(25);
        checkOutput("tc_count", b_log.size() - base_wr, 32'd1);
        checkOutput("tc_addr", {24'd0, b_log[base_wr].addr}, 32'h07);
        checkOutput("tc_data", {16'd0, b_log[base_wr].data}, 32'h2211);
        checkOutput("tc_ferr", b_ferr_cnt - base_ferr, 32'd0);
        checkOutput("tc_errc", {30'd0, b_errc}, 32'd0);

        // Reset in the middle of a frame discards it
        base_wr = b_log.size();
        applyStimulus(8'h44);
        applyStimulus(8'h55);
        goIdle();
        doReset("rst2");
        sendFrame(8'h09, 8'h01, 8'h02);
        waitCycles(3);
        checkOutput("mid_count", b_log.size() - base_wr, 32'd1);
        checkOutput("mid_addr", {24'd0, b_log[base_wr].addr}, 32'h09);
        checkOutput("mid_data", {16'd0, b_log[base_wr].data}, 32'h0201);

        // Error counter saturates at all-ones for a 2-bit counter
        base_wr   = b_log.size();
        base_ferr = b_ferr_cnt;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h10);
            goIdle();
            waitCycles(25);
            exp_err = (i + 1 > 3) ? 32'd3 : 32'(i + 1);
            checkOutput($sformatf("sat_errc%0d", i), {30'd0, b_errc}, exp_err);
        end
        checkOutput("sat_ferr", b_ferr_cnt - base_ferr, 32'd5);
        checkOutput("sat_nowr", b_log.size() - base_wr, 32'd0);

        // Single data byte frames, address taken from the low nibble
        doReset("rst3");
        base_wr = c_log.size();
        applyStimulus(8'h9A);
        applyStimulus(8'h5C);
        applyStimulus(8'h03);
        applyStimulus(8'hF0);
        goIdle();
        waitCycles(3);
        checkOutput("nb1_count", c_log.size() - base_wr, 32'd2);
        checkOutput("nb1_addr0", {24'd0, c_log[base_wr].addr}, 32'h0A);
        checkOutput("nb1_data0", {16'd0, c_log[base_wr].data}, 32'h5C);
        checkOutput("nb1_addr1", {24'd0, c_log[base_wr+1].addr}, 32'h03);
        checkOutput("nb1_data1", {16'd0, c_log[base_wr+1].data}, 32'hF0);
        checkOutput("nb1_gap", c_log[base_wr+1].cyc - c_log[base_wr].cyc, 32'd4);
        checkOutput("nb1_ferr", {31'd0, c_ferr}, 32'd0);
        checkOutput("nb1_errc", {24'd0, c_errc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_protocol.md
Name: rx_protocol

Overview:
- Command decoder on the host-to-device path.
- Consumes bytes from the UART receiver over the SI handshake (data / rdy / ack).
- Parses fixed-length write frames: one address byte, then the data bytes LSB first.
- Issues single-cycle register writes to the configuration register bank.
- Discards incomplete frames after an inter-byte timeout and counts them.

Parameters:
- RX_WIDTH, 8: width of received words from the UART receiver.
- ADDR_WIDTH, 8: register address width; must be <= RX_WIDTH; taken from the low bits of the address byte.
- DATA_WIDTH, 16: register data width. Derived localparam NUM_BYTES = ceil(DATA_WIDTH/RX_WIDTH).
- TIMEOUT_CYCLES, 50000: maximum number of idle clocks allowed between bytes inside a frame.
- ERR_WIDTH, 8: width of the frame error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rx_data  in  RX_WIDTH  received word
- rx_rdy  in  1  rx_data valid; held by the source until acked
- rx_ack  out  1  one-cycle pulse; consumes the current word
- reg_addr  out  ADDR_WIDTH  write address
- reg_data  out  DATA_WIDTH  write data
- reg_wr  out  1  one-cycle write strobe
- frame_err  out  1  one-cycle pulse on frame timeout
- err_count  out  ERR_WIDTH  saturating count of timed-out frames

Behaviour:
- Reset values: rx_ack=0, reg_wr=0, frame_err=0, reg_addr=0, reg_data=0, err_count=0. State ST_IDLE, byte counter 0, timeout counter 0.
- rst mid-frame discards any partial frame. No write is issued.
- Handshake:
  - A word is accepted on a clock edge where rx_rdy=1 and rx_ack=0. On that edge rx_data is captured and rx_ack<=1 for exactly one cycle.
  - rx_rdy is ignored while rx_ack=1, so the minimum spacing between accepted words is 2 cycles.
  - Acceptance is never stalled by this block.
- ST_IDLE:
  - On word acceptance: addr_shadow <= rx_data[ADDR_WIDTH-1:0], byte counter <= 0, timeout counter <= 0, next state ST_DATA.
  - With no word, remain in ST_IDLE. There is no timeout in ST_IDLE.
- ST_DATA:
  - On word acceptance: data byte k (k = byte counter, starting at 0) goes into shadow bits [k*RX_WIDTH +: RX_WIDTH]. Bits beyond DATA_WIDTH in the last byte are dropped. Byte counter increments and timeout counter clears.
  - Acceptance of byte NUM_BYTES-1: on the same edge, reg_addr <= addr_shadow, reg_data <= assembled value, reg_wr <= 1, next state ST_IDLE. reg_wr and the final rx_ack are high in the same cycle.
  - Latency: the write is visible 1 cycle after the last byte is sampled.
  - No word accepted on an edge: the timeout counter increments.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 without a word, go to ST_IDLE, pulse frame_err for 1 cycle, and increment err_count, saturating at all-ones. The partial frame is discarded; no reg_wr is issued.
  - Simultaneous word acceptance and timeout terminal count: the word wins. It is accepted, the timeout counter clears, and there is no error.
- reg_addr and reg_data hold their values between writes and change only together with reg_wr=1.
- Back-to-back frames: a new address byte can be accepted in the cycle right after reg_wr. There is no dead cycle beyond the 2-cycle handshake spacing.
- NUM_BYTES=1 (DATA_WIDTH<=RX_WIDTH): the frame is 2 words and the byte counter is 1 bit wide.
- err_count wraps never; it holds at the maximum value.

Test Plan:
- Frame with defaults, words 0x05, 0x34, 0x12 (rdy held, acked at the minimum spacing): exactly one reg_wr pulse with reg_addr=0x05, reg_data=0x1234; 3 rx_ack pulses; frame_err stays 0.
- Two frames back-to-back, (0x01, 0xAA, 0x55) then (0x02, 0x00, 0xFF): reg_wr pulses carry 0x01/0x55AA and 0x02/0xFF00 in order; reg_data holds 0x55AA between the two pulses.
- TIMEOUT_CYCLES=20; send 0x07, 0x11, then silence for 25 cycles: frame_err pulses once, 19 idle clocks after the 0x11 ack; err_count=1; no reg_wr. A following frame (0x03, 0x22, 0x33) writes 0x03/0x3322.
- TIMEOUT_CYCLES=20; deliver the second data byte exactly on the terminal-count cycle: the byte is accepted, reg_wr fires with the correct data, and err_count is unchanged.
- Assert rst after the address byte and one data byte, then send 0x09, 0x01, 0x02: all outputs return to 0 during reset; the only write seen is 0x09/0x0201.
- ERR_WIDTH=2; force 5 timeouts: err_count reads 1, 2, 3, 3, 3; frame_err pulses 5 times.
